// File: rtl/input_conditioner.sv
// input_conditioner: raw board buttons -> moveLeft / moveRight / laserOn for the game RAM.
// Each button runs through a 2-FF synchroniser and a debouncer. Left/right are arbitrated so
// that both pressed yields neither. The fire button triggers a one-shot laser pulse followed
// by a cooldown window.
// Build option: define AUTOFIRE_EN to make a held fire button re-fire after every cooldown.
//
// state | meaning
// IDLE  | waiting for a fire trigger, laserOn low
// FIRE  | laserOn high, tmr counts the hold window
// COOL  | laserOn low, tmr counts the cooldown, fire ignored
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LASER_HOLD      = 1024,
  parameter int COOLDOWN_CYCLES = 5000000,
  parameter int CNT_WIDTH       = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btnLeft,
  input  logic       btnRight,
  input  logic       btnFire,
  output logic       moveLeft,
  output logic       moveRight,
  output logic       laserOn,
  output logic [7:0] shotCount
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] DB_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(LASER_HOLD - 1);
  localparam logic [CNT_WIDTH-1:0] COOL_LAST = CNT_WIDTH'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FIRE = 2'b01,
    COOL = 2'b10
  } state_t;

  // bit 0 = left, bit 1 = right, bit 2 = fire
  logic [2:0]           raw;
  logic [2:0]           s1;
  logic [2:0]           s2;
  logic [2:0]           db;
  logic [CNT_WIDTH-1:0] db_cnt [3];

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] tmr;
  logic [CNT_WIDTH-1:0] tmr_nxt;
  logic                 laser_nxt;
  logic [7:0]           shot_nxt;
  logic                 trigger;

  assign raw = {btnFire, btnRight, btnLeft};

  // Two-stage synchroniser for the asynchronous buttons.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Mutually exclusive move levels, one edge after the debounced states.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      moveLeft  <= 1'b0;
      moveRight <= 1'b0;
    end else begin
      moveLeft  <= db[0] & ~db[1];
      moveRight <= db[1] & ~db[0];
    end
  end

`ifdef AUTOFIRE_EN
  assign trigger = db[2];
`else
  logic db_f_d;

  // Delayed fire level for rise detection; runs in every FSM state so a press that began
  // during cooldown has already been consumed when the FSM returns to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) db_f_d <= 1'b0;
    else          db_f_d <= db[2];
  end

  assign trigger = db[2] & ~db_f_d;
`endif

  // FSM state, timer and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      tmr       <= '0;
      laserOn   <= 1'b0;
      shotCount <= 8'd0;
    end else begin
      state     <= state_nxt;
      tmr       <= tmr_nxt;
      laserOn   <= laser_nxt;
      shotCount <= shot_nxt;
    end
  end

  // Next-state and timer logic.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_nxt = FIRE;
          tmr_nxt   = '0;
        end
      end
      FIRE: begin
        if (tmr == HOLD_LAST) begin
          state_nxt = COOL;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr + CNT_ONE;
        end
      end
      COOL: begin
        if (tmr == COOL_LAST) begin
          state_nxt = IDLE;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        tmr_nxt   = '0;
      end
    endcase
  end

  // Output logic: laser level and shot counter (wraps silently at 255).
  always_comb begin
    laser_nxt = laserOn;
    shot_nxt  = shotCount;
    case (state)
      IDLE: begin
        if (trigger) begin
          laser_nxt = 1'b1;
          shot_nxt  = shotCount + 8'd1;
        end
      end
      FIRE: begin
        if (tmr == HOLD_LAST) laser_nxt = 1'b0;
      end
      COOL: laser_nxt = 1'b0;
      default: laser_nxt = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btnLeft, btnRight, btnFire;
  logic       moveLeft, moveRight, laserOn;
  logic [7:0] shotCount;

  // second instance with a long cooldown so a full debounced re-press fits inside COOL
  logic       fire2;
  logic       ml2, mr2, laser2;
  logic [7:0] shot2;

  int n_cmp = 0;
  int n_err = 0;
  int exp_shot = 0;

  always #5 clk = ~clk;

  input_conditioner #(
    .DEBOUNCE_CYCLES(4), .LASER_HOLD(3), .COOLDOWN_CYCLES(5), .CNT_WIDTH(8)
  ) u_dut (
    .clk(clk), .reset_n(reset_n),
    .btnLeft(btnLeft), .btnRight(btnRight), .btnFire(btnFire),
    .moveLeft(moveLeft), .moveRight(moveRight), .laserOn(laserOn), .shotCount(shotCount)
  );

  input_conditioner #(
    .DEBOUNCE_CYCLES(4), .LASER_HOLD(3), .COOLDOWN_CYCLES(20), .CNT_WIDTH(8)
  ) u_dut_cool (
    .clk(clk), .reset_n(reset_n),
    .btnLeft(1'b0), .btnRight(1'b0), .btnFire(fire2),
    .moveLeft(ml2), .moveRight(mr2), .laserOn(laser2), .shotCount(shot2)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press_fire();
    btnFire = 1'b1;
    repeat (6) step();
    btnFire = 1'b0;
    repeat (14) step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; btnLeft = 1'b0; btnRight = 1'b0; btnFire = 1'b0; fire2 = 1'b0;
    #1;
    n_cmp++; if (moveLeft !== 1'b0)   begin n_err++; $display("FAIL reset_moveLeft got %b want 0", moveLeft); end
    n_cmp++; if (moveRight !== 1'b0)  begin n_err++; $display("FAIL reset_moveRight got %b want 0", moveRight); end
    n_cmp++; if (laserOn !== 1'b0)    begin n_err++; $display("FAIL reset_laserOn got %b want 0", laserOn); end
    n_cmp++; if (shotCount !== 8'd0)  begin n_err++; $display("FAIL reset_shotCount got %0d want 0", shotCount); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 20; i++) begin
      btnLeft = ((i / 2) % 2) == 0;
      step();
      n_cmp++; if (moveLeft !== 1'b0) begin n_err++; $display("FAIL bounce_moveLeft cycle %0d got %b want 0", i, moveLeft); end
    end
    btnLeft = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++; if (moveLeft !== 1'b0) begin n_err++; $display("FAIL bounce_settle cycle %0d got %b want 0", i, moveLeft); end
    end
  endtask

  task automatic test_clean_step();
    btnLeft = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      n_cmp++; if (moveLeft !== (i == 7)) begin n_err++; $display("FAIL step_rise edge %0d got %b want %b", i, moveLeft, (i == 7)); end
    end
    btnLeft = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      n_cmp++; if (moveLeft !== (i < 7)) begin n_err++; $display("FAIL step_fall edge %0d got %b want %b", i, moveLeft, (i < 7)); end
    end
  endtask

  task automatic test_both();
    btnLeft = 1'b1; btnRight = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      n_cmp++; if ({moveLeft, moveRight} !== 2'b00) begin n_err++; $display("FAIL both_held edge %0d got %b%b want 00", i, moveLeft, moveRight); end
    end
    btnRight = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      n_cmp++; if (moveLeft !== (i == 7)) begin n_err++; $display("FAIL both_left edge %0d got %b want %b", i, moveLeft, (i == 7)); end
      n_cmp++; if (moveRight !== 1'b0)    begin n_err++; $display("FAIL both_right edge %0d got %b want 0", i, moveRight); end
    end
    btnLeft = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_fire();
    logic exp_l;
    btnFire = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
`ifdef AUTOFIRE_EN
      exp_l = (i >= 7) && (((i - 7) % 9) < 3);
      if (exp_l && ((i - 7) % 9) == 0) exp_shot++;
`else
      exp_l = (i >= 7) && (i <= 9);
      if (i == 7) exp_shot++;
`endif
      n_cmp++; if (laserOn !== exp_l) begin n_err++; $display("FAIL fire_laser edge %0d got %b want %b", i, laserOn, exp_l); end
    end
    n_cmp++; if (shotCount !== 8'(exp_shot)) begin n_err++; $display("FAIL fire_count_held got %0d want %0d", shotCount, exp_shot); end
    btnFire = 1'b0;
`ifdef AUTOFIRE_EN
    exp_shot++;  // debounced level is still high at the IDLE evaluation after release
`endif
    repeat (20) step();
    n_cmp++; if (shotCount !== 8'(exp_shot)) begin n_err++; $display("FAIL fire_count_released got %0d want %0d", shotCount, exp_shot); end
    n_cmp++; if (laserOn !== 1'b0) begin n_err++; $display("FAIL fire_laser_idle got %b want 0", laserOn); end
  endtask

  task automatic test_cool_press();
    logic exp_l;
    for (int i = 1; i <= 45; i++) begin
      fire2 = (i <= 6) || (i >= 13 && i <= 20);
      step();
      exp_l = (i >= 7) && (i <= 9);
      n_cmp++; if (laser2 !== exp_l) begin n_err++; $display("FAIL cool_laser edge %0d got %b want %b", i, laser2, exp_l); end
    end
    n_cmp++; if (shot2 !== 8'd1) begin n_err++; $display("FAIL cool_count got %0d want 1", shot2); end
    n_cmp++; if (ml2 !== 1'b0)   begin n_err++; $display("FAIL cool_move got %b want 0", ml2); end
    fire2 = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      n_cmp++; if (laser2 !== (i == 7)) begin n_err++; $display("FAIL idle_refire edge %0d got %b want %b", i, laser2, (i == 7)); end
    end
    n_cmp++; if (shot2 !== 8'd2) begin n_err++; $display("FAIL idle_refire_count got %0d want 2", shot2); end
    fire2 = 1'b0;
    repeat (30) step();
  endtask

  task automatic test_reset_mid();
    btnFire = 1'b1; btnLeft = 1'b1;
    repeat (8) step();
    exp_shot++;
    n_cmp++; if (laserOn !== 1'b1)  begin n_err++; $display("FAIL mid_laser_pre got %b want 1", laserOn); end
    n_cmp++; if (moveLeft !== 1'b1) begin n_err++; $display("FAIL mid_left_pre got %b want 1", moveLeft); end
    btnRight = 1'b1;
    repeat (3) step();
    #1 reset_n = 1'b0;
    #1;
    n_cmp++; if (laserOn !== 1'b0)   begin n_err++; $display("FAIL mid_reset_laser got %b want 0", laserOn); end
    n_cmp++; if (moveLeft !== 1'b0)  begin n_err++; $display("FAIL mid_reset_left got %b want 0", moveLeft); end
    n_cmp++; if (shotCount !== 8'd0) begin n_err++; $display("FAIL mid_reset_count got %0d want 0", shotCount); end
    exp_shot = 0;
    btnFire = 1'b0; btnLeft = 1'b0; btnRight = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    step();
    n_cmp++; if ({moveLeft, moveRight, laserOn} !== 3'b000) begin n_err++; $display("FAIL post_reset_outs got %b%b%b want 000", moveLeft, moveRight, laserOn); end
    btnFire = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      n_cmp++; if (laserOn !== (i == 7)) begin n_err++; $display("FAIL post_reset_fire edge %0d got %b want %b", i, laserOn, (i == 7)); end
    end
    exp_shot++;
    n_cmp++; if (shotCount !== 8'(exp_shot)) begin n_err++; $display("FAIL post_reset_count got %0d want %0d", shotCount, exp_shot); end
    btnFire = 1'b0;
    repeat (20) step();
  endtask

  task automatic test_wrap();
    #1 reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    exp_shot = 0;
    repeat (255) begin
      press_fire();
      exp_shot++;
    end
    n_cmp++; if (shotCount !== 8'(exp_shot)) begin n_err++; $display("FAIL wrap_255 got %0d want %0d", shotCount, exp_shot); end
    press_fire();
    exp_shot = 0;
    n_cmp++; if (shotCount !== 8'd0) begin n_err++; $display("FAIL wrap_0 got %0d want 0", shotCount); end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_step();
    test_both();
    test_fire();
    test_cool_press();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
